// File: rtl/bcp_clause_scanner.sv
// Boolean-constraint-propagation clause scanner: walks a clause range, evaluates each
// clause against var state, pushes unit implications or flags a conflict. Optional macro: BCP_STATS_EN.
module bcp_clause_scanner #(
  parameter int VAR_BITS    = 6,
  parameter int NUM_VARS    = 64,
  parameter int CLAUSE_BITS = 8,
  parameter int LITS        = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CLAUSE_BITS-1:0]   start_clause,
  input  logic [CLAUSE_BITS-1:0]   end_clause,
  output logic                     clause_rd_en,
  output logic [CLAUSE_BITS-1:0]   clause_rd_idx,
  input  logic [LITS*VAR_BITS-1:0] clause_vars,
  input  logic [LITS-1:0]          clause_pols,
  input  logic [LITS-1:0]          clause_lit_valid,
  input  logic [NUM_VARS-1:0]      var_assigned,
  input  logic [NUM_VARS-1:0]      var_value,
  input  logic                     full_imply,
  output logic                     push_imply,
  output logic [VAR_BITS-1:0]      var_out_imply,
  output logic                     val_out_imply,
  output logic                     bcp_busy,
  output logic                     conflict,
  output logic [CLAUSE_BITS-1:0]   bcp_clause_idx,
  output logic                     done
`ifdef BCP_STATS_EN
  ,
  output logic [CLAUSE_BITS-1:0]   clauses_scanned,
  output logic [CLAUSE_BITS-1:0]   units_found
`endif
);

  localparam int CNT_W = $clog2(LITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_PUSH_WAIT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [CLAUSE_BITS-1:0] idx;
  logic [CLAUSE_BITS-1:0] last;
  logic [VAR_BITS-1:0]    hold_var;
  logic                   hold_val;

  logic                   any_true;
  logic [CNT_W-1:0]       n_unassigned;
  logic [VAR_BITS-1:0]    unit_var;
  logic                   unit_val;
  logic                   is_unit;
  logic                   is_conflict;
  logic                   advance;

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    any_true     = 1'b0;
    n_unassigned = '0;
    unit_var     = '0;
    unit_val     = 1'b0;
    for (int k = 0; k < LITS; k++) begin
      if (clause_lit_valid[k]) begin
        if (var_assigned[clause_vars[k*VAR_BITS +: VAR_BITS]]) begin
          if (var_value[clause_vars[k*VAR_BITS +: VAR_BITS]] == clause_pols[k])
            any_true = 1'b1;
        end else begin
          n_unassigned = n_unassigned + CNT_W'(1);
          unit_var     = clause_vars[k*VAR_BITS +: VAR_BITS];
          unit_val     = clause_pols[k];
        end
      end
    end
  end

  // An empty clause (no valid slots) falls out as a conflict naturally.
  assign is_conflict = !any_true && (n_unassigned == '0);
  assign is_unit     = !any_true && (n_unassigned == CNT_W'(1));

  // Clause evaluation finished without conflict and without a stall.
  assign advance = ((state == S_EVAL) && !is_conflict && !(is_unit && full_imply)) ||
                   ((state == S_PUSH_WAIT) && !full_imply);

  assign clause_rd_en  = (state == S_FETCH);
  assign clause_rd_idx = idx;
  assign bcp_busy      = (state == S_FETCH) || (state == S_EVAL) || (state == S_PUSH_WAIT);
  assign done          = (state == S_DONE);
  assign push_imply    = ((state == S_EVAL) && is_unit && !full_imply) ||
                         ((state == S_PUSH_WAIT) && !full_imply);
  assign var_out_imply = ((state == S_EVAL) && is_unit) ? unit_var : hold_var;
  assign val_out_imply = ((state == S_EVAL) && is_unit) ? unit_val : hold_val;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      last           <= '0;
      hold_var       <= '0;
      hold_val       <= 1'b0;
      conflict       <= 1'b0;
      bcp_clause_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            conflict <= 1'b0;
            if (start_clause <= end_clause) begin
              idx   <= start_clause;
              last  <= end_clause;
              state <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_FETCH: state <= S_EVAL;
        S_EVAL: begin
          if (is_unit) begin
            hold_var <= unit_var;
            hold_val <= unit_val;
          end
          if (is_conflict) begin
            conflict       <= 1'b1;
            bcp_clause_idx <= idx;
            state          <= S_DONE;
          end else if (is_unit && full_imply) begin
            state <= S_PUSH_WAIT;
          end
        end
        S_PUSH_WAIT: ;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Equality against last (not idx+1 > last) keeps an all-ones end from wrapping.
      if (advance) begin
        if (idx == last) begin
          state <= S_DONE;
        end else begin
          idx   <= idx + CLAUSE_BITS'(1);
          state <= S_FETCH;
        end
      end
    end
  end

`ifdef BCP_STATS_EN
  logic eval_complete;
  assign eval_complete = advance || ((state == S_EVAL) && is_conflict);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clauses_scanned <= '0;
      units_found     <= '0;
    end else if ((state == S_IDLE) && start) begin
      clauses_scanned <= '0;
      units_found     <= '0;
    end else begin
      if (eval_complete && (clauses_scanned != '1))
        clauses_scanned <= clauses_scanned + CLAUSE_BITS'(1);
      if (push_imply && (units_found != '1))
        units_found <= units_found + CLAUSE_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bcp_clause_scanner.sv
// Scoreboard bench for bcp_clause_scanner: a clause-level reference model queues expected
// implications and scan outcomes; an independent monitor checks them as the DUT produces them.
module tb_bcp_clause_scanner;

  localparam int VB = 6;
  localparam int NV = 64;
  localparam int CB = 8;
  localparam int L  = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CB-1:0]     start_clause = '0;
  logic [CB-1:0]     end_clause = '0;
  logic              clause_rd_en;
  logic [CB-1:0]     clause_rd_idx;
  logic [L*VB-1:0]   clause_vars = '0;
  logic [L-1:0]      clause_pols = '0;
  logic [L-1:0]      clause_lit_valid = '0;
  logic [NV-1:0]     var_assigned = '0;
  logic [NV-1:0]     var_value = '0;
  logic              full_imply = 1'b0;
  logic              push_imply;
  logic [VB-1:0]     var_out_imply;
  logic              val_out_imply;
  logic              bcp_busy;
  logic              conflict;
  logic [CB-1:0]     bcp_clause_idx;
  logic              done;

  always #5 clock = ~clock;

  bcp_clause_scanner #(.VAR_BITS(VB), .NUM_VARS(NV), .CLAUSE_BITS(CB), .LITS(L)) dut (
    .clock(clock), .reset(reset), .start(start),
    .start_clause(start_clause), .end_clause(end_clause),
    .clause_rd_en(clause_rd_en), .clause_rd_idx(clause_rd_idx),
    .clause_vars(clause_vars), .clause_pols(clause_pols), .clause_lit_valid(clause_lit_valid),
    .var_assigned(var_assigned), .var_value(var_value), .full_imply(full_imply),
    .push_imply(push_imply), .var_out_imply(var_out_imply), .val_out_imply(val_out_imply),
    .bcp_busy(bcp_busy), .conflict(conflict), .bcp_clause_idx(bcp_clause_idx), .done(done)
  );

  // Clause memory with one-cycle read latency.
  logic [L*VB-1:0] mem_vars  [256];
  logic [L-1:0]    mem_pols  [256];
  logic [L-1:0]    mem_valid [256];

  always @(posedge clock) begin
    if (clause_rd_en) begin
      clause_vars      <= mem_vars[clause_rd_idx];
      clause_pols      <= mem_pols[clause_rd_idx];
      clause_lit_valid <= mem_valid[clause_rd_idx];
    end
  end

  // Imply-stack backpressure, changed just after the rising edge.
  logic rand_full   = 1'b0;
  logic forced_full = 1'b0;
  always @(posedge clock) begin
    #1;
    full_imply = rand_full ? ($urandom_range(0, 3) == 0) : forced_full;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [VB-1:0] v; logic val; } imp_t;
  typedef struct packed { logic conf; logic [CB-1:0] idx; } out_t;
  imp_t exp_imp[$];
  out_t exp_out[$];

  // Reference: classify each clause by counting true and unassigned literals.
  task automatic model_scan(input int s, input int e);
    out_t o;
    o.conf = 1'b0;
    o.idx  = '0;
    for (int c = s; c <= e; c++) begin
      int   ntrue = 0;
      int   nunk  = 0;
      imp_t u     = '0;
      for (int k = 0; k < L; k++) begin
        logic [L*VB-1:0] row;
        logic [VB-1:0]   lv;
        row = mem_vars[c];
        lv  = row[k*VB +: VB];
        if (mem_valid[c][k]) begin
          if (!var_assigned[lv]) begin
            nunk++;
            u.v   = lv;
            u.val = mem_pols[c][k];
          end else if (var_value[lv] == mem_pols[c][k]) begin
            ntrue++;
          end
        end
      end
      if (ntrue == 0 && nunk == 0) begin
        o.conf = 1'b1;
        o.idx  = CB'(c);
        break;
      end
      if (ntrue == 0 && nunk == 1) exp_imp.push_back(u);
    end
    exp_out.push_back(o);
  endtask

  // Monitor: compares DUT activity against the queues on the falling edge.
  int   scans_done = 0;
  int   busy_cnt   = 0;
  int   rd_cnt     = 0;
  int   max_rd     = 0;
  int   pushes     = 0;
  imp_t mon_imp;
  out_t mon_out;

  always @(negedge clock) begin
    if (!reset) begin
      if (bcp_busy) busy_cnt++;
      if (clause_rd_en) begin
        rd_cnt++;
        if (int'(clause_rd_idx) > max_rd) max_rd = int'(clause_rd_idx);
      end
      if (push_imply) begin
        pushes++;
        check("push_while_full", full_imply, 0);
        if (exp_imp.size() == 0) begin
          check("push_unexpected", push_imply, 0);
        end else begin
          mon_imp = exp_imp.pop_front();
          check("imply_var", var_out_imply, mon_imp.v);
          check("imply_val", val_out_imply, mon_imp.val);
        end
      end
      if (done) begin
        if (exp_out.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          mon_out = exp_out.pop_front();
          check("conflict", conflict, mon_out.conf);
          if (mon_out.conf) check("conflict_idx", bcp_clause_idx, mon_out.idx);
          check("missing_implies", exp_imp.size(), 0);
        end
        scans_done++;
      end
    end
  end

  int scan_target = 0;

  // Returns on the falling edge after the start pulse (DUT in its first post-start state).
  task automatic start_scan(input int s, input int e);
    model_scan(s, e);
    @(negedge clock);
    scan_target  = scans_done + 1;
    busy_cnt     = 0;
    rd_cnt       = 0;
    max_rd       = 0;
    start        = 1'b1;
    start_clause = CB'(s);
    end_clause   = CB'(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      if (scans_done >= scan_target) return;
      @(negedge clock);
      #1;
    end
    check("scan_timeout", scans_done, scan_target);
  endtask

  // Every clause satisfied by x0=1, which the var state keeps assigned true.
  task automatic fill_sat();
    for (int c = 0; c < 256; c++) begin
      mem_vars[c]  = '0;
      mem_pols[c]  = 3'b001;
      mem_valid[c] = 3'b001;
    end
  endtask

  // (x1, ~x2, x7) with x1=0, x2=1 assigned and x7 free: unit implying x7=1.
  task automatic put_unit(input int c);
    mem_vars[c]  = {6'd7, 6'd2, 6'd1};
    mem_pols[c]  = 3'b101;
    mem_valid[c] = 3'b111;
  endtask

  task automatic set_directed_vars();
    var_assigned = '0;
    var_value    = '0;
    var_assigned[0] = 1'b1; var_value[0] = 1'b1;
    var_assigned[1] = 1'b1; var_value[1] = 1'b0;
    var_assigned[2] = 1'b1; var_value[2] = 1'b1;
  endtask

  int p0;

  initial begin
    fill_sat();
    set_directed_vars();

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_rd_en", clause_rd_en, 0);
    check("rst_rd_idx", clause_rd_idx, 0);
    check("rst_push", push_imply, 0);
    check("rst_var_out", var_out_imply, 0);
    check("rst_busy", bcp_busy, 0);
    check("rst_conflict", conflict, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Satisfied scan: 2 cycles per clause, no implications
    start_scan(0, 3);
    wait_done();
    check("sat_busy_cycles", busy_cnt, 8);

    // Unit clause in the middle of a range
    put_unit(5);
    p0 = pushes;
    start_scan(4, 6);
    wait_done();
    check("unit_push_count", pushes - p0, 1);

    // Backpressure: full for EVAL plus two PUSH_WAIT cycles, then one push
    forced_full = 1'b1;
    @(negedge clock);
    start_scan(5, 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_push_held", push_imply, 0);
      check("bp_var_held", var_out_imply, 7);
      check("bp_val_held", val_out_imply, 1);
      check("bp_busy", bcp_busy, 1);
    end
    forced_full = 1'b0;
    @(negedge clock);
    #1;
    check("bp_push", push_imply, 1);
    check("bp_var", var_out_imply, 7);
    check("bp_val", val_out_imply, 1);
    wait_done();
    check("bp_reads", rd_cnt, 2);

    // Conflict abort: clause 4 is (x1, x1, x1) with x1=0
    fill_sat();
    mem_vars[4]  = {6'd1, 6'd1, 6'd1};
    mem_pols[4]  = 3'b111;
    mem_valid[4] = 3'b111;
    start_scan(0, 10);
    wait_done();
    check("abort_max_rd", max_rd, 4);
    repeat (3) @(negedge clock);
    check("conflict_sticky", conflict, 1);
    check("conflict_idx_sticky", bcp_clause_idx, 4);

    // Empty range: done the cycle after start, busy never, conflict cleared
    start_scan(9, 8);
    check("empty_done", done, 1);
    check("empty_conflict_clr", conflict, 0);
    wait_done();
    check("empty_busy", busy_cnt, 0);

    // Top-of-range single clause: one read at 255, no wrap
    put_unit(255);
    start_scan(255, 255);
    wait_done();
    check("top_reads", rd_cnt, 1);
    check("top_max_rd", max_rd, 255);

    // Reset during EVAL of clause 2 (a unit clause)
    fill_sat();
    put_unit(2);
    start_scan(0, 5);
    repeat (5) @(negedge clock);
    #2;
    p0 = pushes;
    reset = 1'b1;
    #1;
    check("mid_rst_rd_en", clause_rd_en, 0);
    check("mid_rst_rd_idx", clause_rd_idx, 0);
    check("mid_rst_push", push_imply, 0);
    check("mid_rst_var_out", var_out_imply, 0);
    check("mid_rst_val_out", val_out_imply, 0);
    check("mid_rst_busy", bcp_busy, 0);
    check("mid_rst_done", done, 0);
    exp_imp.delete();
    exp_out.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("post_rst_pushes", pushes - p0, 0);
    check("post_rst_busy", bcp_busy, 0);

    // Randomized scans with random backpressure
    rand_full = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int s;
      int e;
      var_assigned = {$urandom, $urandom} | {$urandom, $urandom};
      var_value    = {$urandom, $urandom};
      for (int c = 0; c < 256; c++) begin
        mem_vars[c]  = L*VB'({$urandom, $urandom});
        mem_pols[c]  = L'($urandom);
        mem_valid[c] = ($urandom_range(0, 15) == 0) ? 3'b000 : L'($urandom_range(1, 7));
      end
      s = $urandom_range(0, 255);
      e = s + $urandom_range(0, 12);
      if (e > 255) e = 255;
      if (s > 0 && $urandom_range(0, 7) == 0) e = s - 1;
      start_scan(s, e);
      wait_done();
      @(negedge clock);
    end
    rand_full = 1'b0;
    repeat (3) @(negedge clock);
    check("leftover_outcomes", exp_out.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcp_clause_scanner.md
Name: bcp_clause_scanner

Overview:
- Boolean-constraint-propagation engine directly downstream of control.
- On a start pulse, walks the clause index range [start_clause, end_clause] that the var start/end table returned for the last-assigned variable.
- For each clause: fetches literals from clause memory and evaluates them against the var-state vectors.
- Pushes unit implications into the imply stack, or flags a conflict; control observes busy/conflict/done.

Parameters:
- VAR_BITS, 6, width of a variable index (equals `MAX_VARS_BITS).
- NUM_VARS, 64, number of variables; 2**VAR_BITS.
- CLAUSE_BITS, 8, width of a clause index (equals `MAX_CLAUSES_BITS).
- LITS, 3, maximum literal slots per clause.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle pulse from control; begins a scan.
- start_clause, in, CLAUSE_BITS, first clause index (inclusive).
- end_clause, in, CLAUSE_BITS, last clause index (inclusive).
- clause_rd_en, out, 1, clause memory read strobe.
- clause_rd_idx, out, CLAUSE_BITS, clause memory read address.
- clause_vars, in, LITS*VAR_BITS, literal variable indices; slot k is at [k*VAR_BITS +: VAR_BITS]. Valid the cycle after clause_rd_en.
- clause_pols, in, LITS, literal polarity; 1 = positive literal.
- clause_lit_valid, in, LITS, slot-used mask.
- var_assigned, in, NUM_VARS, per-variable assigned bit from var state.
- var_value, in, NUM_VARS, per-variable value from var state.
- full_imply, in, 1, imply stack full.
- push_imply, out, 1, imply stack push.
- var_out_imply, out, VAR_BITS, implied variable.
- val_out_imply, out, 1, implied value.
- bcp_busy, out, 1, scan in progress.
- conflict, out, 1, sticky conflict flag.
- bcp_clause_idx, out, CLAUSE_BITS, index of the conflicting clause.
- done, out, 1, one-cycle scan-complete pulse.

Behaviour:
- Reset (async): state IDLE. All outputs 0: clause_rd_en, clause_rd_idx, push_imply, var_out_imply, val_out_imply, bcp_busy, conflict, bcp_clause_idx, done.
- FSM states: IDLE, FETCH, EVAL, PUSH_WAIT, DONE.
- IDLE:
  - start=1 with start_clause<=end_clause: latch idx=start_clause and last=end_clause, clear conflict, go to FETCH.
  - start=1 with start_clause>end_clause: clear conflict, go to DONE.
  - start=0: stay in IDLE.
- FETCH: clause_rd_en=1, clause_rd_idx=idx (combinational from state), go to EVAL.
- EVAL: evaluates the memory data returned this cycle, combinationally, in valid slots only.
  - Literal true: assigned and value==pol. Literal false: assigned and value!=pol. Otherwise unassigned.
- EVAL outcomes:
  - Any literal true: clause satisfied, no action.
  - Zero unassigned and none true: set conflict=1, bcp_clause_idx=idx, go to DONE (remaining clauses abandoned).
  - Exactly one unassigned and none true: unit. Drive var_out_imply=that var and val_out_imply=its pol.
    - If !full_imply: push_imply=1 this cycle.
    - Else: latch var/val and go to PUSH_WAIT.
  - Two or more unassigned: no action.
- EVAL next state (non-conflict, not stalled): if idx==last go to DONE, else idx<=idx+1 and go to FETCH. Cost is 2 cycles per clause.
- PUSH_WAIT: hold var_out_imply/val_out_imply. push_imply=0 while full_imply=1. First cycle full_imply=0: push_imply=1, then advance as in EVAL.
- DONE: done=1 for one cycle, go to IDLE. conflict holds until the next start or reset.
- bcp_busy=1 in FETCH, EVAL, PUSH_WAIT; 0 in IDLE and DONE.
- start is ignored outside IDLE.
- idx==last comparison prevents wrap when end_clause is all ones.
- Clause with no valid slots: counts as a conflict.
- Duplicate or contradictory implications from different clauses are pushed as-is; control resolves them.
- Control must not write var state while bcp_busy=1.
- Reset mid-scan: immediate return to IDLE. No push_imply asserted after reset.

Optional Feature:
- Macro: BCP_STATS_EN.
- Defined: adds outputs clauses_scanned[CLAUSE_BITS] and units_found[CLAUSE_BITS].
  - Both clear on start and on reset.
  - clauses_scanned increments once per clause whose evaluation completes (the conflict clause counts; PUSH_WAIT stall cycles do not).
  - units_found increments on each push_imply.
  - Both saturate at all-ones.
- Undefined: those ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-scan: assert reset during EVAL of clause 2 → all outputs 0 that cycle; state IDLE; no push after reset.
- Satisfied scan: range 0..3, every clause holds one true literal → bcp_busy high exactly 8 cycles, no push_imply, done pulse, conflict=0.
- Unit: clause 5 = (x1, ~x2, x7), x1=0 assigned, x2=1 assigned, x7 unassigned → one push_imply with var_out_imply=7, val_out_imply=1.
- Conflict abort: range 0..10, clause 4 has all literals false → conflict=1, bcp_clause_idx=4, clause_rd_idx never exceeds 4, done follows; conflict holds until next start.
- Backpressure: unit found with full_imply=1 for 3 cycles → push_imply=0 for 3 cycles, then 1 for one cycle with var/val unchanged; scan resumes.
- Edge ranges:
  - start_clause=9, end_clause=8 → bcp_busy never asserts, done the cycle after start.
  - start_clause=end_clause=255 → single clause read at 255, no wrap.
